logic_operand_stage: RTL and testbench

// - Issue stage directly upstream of logic_controller. Holds an 8-entry x 8-bit register file.
// - Accepts one logic instruction per valid/ready handshake: opcode, rd, ra, rb.
// - Reads operands ra/rb and drives lu_opcode/lu_a/lu_b into logic_controller, which is combinational.
// - Captures lu_y, writes it back to rd, and presents it on a valid/ready result stream.

---
 rtl/logic_operand_stage.sv | 152 +++++++++++++++
 tb/tb_logic_operand_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_operand_stage.sv
// Issue stage ahead of the combinational logic_controller: 8x8 register file, operand read with
// ext-write bypass, writeback of lu_y and a valid/ready result stream. Optional flags: LOGIC_FLAGS_EN.
module logic_operand_stage #(
    parameter int         NREGS     = 8,
    parameter logic [7:0] RESET_VAL = 8'h00,
    localparam int        AW        = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_opcode,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_ra,
    input  logic [AW-1:0] in_rb,
    input  logic          ext_wr_en,
    input  logic [AW-1:0] ext_wr_addr,
    input  logic [7:0]    ext_wr_data,
    output logic [7:0]    lu_opcode,
    output logic [7:0]    lu_a,
    output logic [7:0]    lu_b,
    input  logic [7:0]    lu_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [AW-1:0] out_rd,
`ifdef LOGIC_FLAGS_EN
    output logic          out_zero,
    output logic          out_neg,
`endif
    output logic          out_err
);

    localparam logic [7:0] OP_NOT = 8'h07;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    regs_q [NREGS];
    logic [7:0]    lu_opcode_q, lu_a_q, lu_b_q;
    logic [AW-1:0] rd_q;
    logic [7:0]    out_data_q, out_data_d;
    logic [AW-1:0] out_rd_q;
    logic          out_err_q;
    logic [7:0]    a_d, b_d;
    logic          accept, exec_ok;

    function automatic logic op_ok(input logic [7:0] op);
        return (op >= 8'h01) && (op <= 8'h07);
    endfunction

    // A same-cycle external load to the operand address is forwarded into the latched operand.
    function automatic logic [7:0] read_bypass(input logic [AW-1:0] addr, input logic [7:0] rf_val,
                                               input logic wen, input logic [AW-1:0] waddr,
                                               input logic [7:0] wdata);
        return (wen && (waddr == addr)) ? wdata : rf_val;
    endfunction

    assign accept  = (state_q == IDLE) && in_valid;
    assign exec_ok = op_ok(lu_opcode_q);

    always_comb begin
        a_d = read_bypass(in_ra, regs_q[in_ra], ext_wr_en, ext_wr_addr, ext_wr_data);
        b_d = read_bypass(in_rb, regs_q[in_rb], ext_wr_en, ext_wr_addr, ext_wr_data);
        if (in_opcode == OP_NOT) begin
            b_d = 8'h00;
        end
    end

    assign out_data_d = exec_ok ? lu_y : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = EXEC;
            EXEC:                   state_d = RESP;
            RESP:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == RESP);
    end

    // Operand latch (IDLE accept) and result capture / writeback (EXEC)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_opcode_q <= 8'h00;
            lu_a_q      <= 8'h00;
            lu_b_q      <= 8'h00;
            rd_q        <= '0;
            out_data_q  <= 8'h00;
            out_rd_q    <= '0;
            out_err_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            if (accept) begin
                lu_opcode_q <= in_opcode;
                rd_q        <= in_rd;
                lu_a_q      <= a_d;
                lu_b_q      <= b_d;
            end
            if (state_q == EXEC) begin
                out_data_q <= out_data_d;
                out_rd_q   <= rd_q;
                out_err_q  <= !exec_ok;
            end
            if ((state_q == IDLE) && ext_wr_en) begin
                regs_q[ext_wr_addr] <= ext_wr_data;
            end else if ((state_q == EXEC) && exec_ok) begin
                regs_q[rd_q] <= lu_y;
            end
        end
    end

`ifdef LOGIC_FLAGS_EN
    logic out_zero_q, out_neg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_zero_q <= 1'b0;
            out_neg_q  <= 1'b0;
        end else if (state_q == EXEC) begin
            out_zero_q <= (out_data_d == 8'h00);
            out_neg_q  <= out_data_d[7];
        end
    end

    assign out_zero = out_zero_q;
    assign out_neg  = out_neg_q;
`endif

    assign lu_opcode = lu_opcode_q;
    assign lu_a      = lu_a_q;
    assign lu_b      = lu_b_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_logic_operand_stage.sv
// Bench for logic_operand_stage: behavioural logic_controller, register-file model and a result
// scoreboard popped on each out_valid/out_ready handshake.
module tb_logic_operand_stage;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_opcode = 8'h00;
    logic [AW-1:0] in_rd = '0, in_ra = '0, in_rb = '0;
    logic          ext_wr_en = 1'b0;
    logic [AW-1:0] ext_wr_addr = '0;
    logic [7:0]    ext_wr_data = 8'h00;
    logic [7:0]    lu_opcode, lu_a, lu_b, lu_y;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic [AW-1:0] out_rd;
    logic          out_err;
`ifdef LOGIC_FLAGS_EN
    logic          out_zero, out_neg;
`endif

    logic_operand_stage #(.NREGS(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
        .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .lu_opcode(lu_opcode), .lu_a(lu_a), .lu_b(lu_b), .lu_y(lu_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
`ifdef LOGIC_FLAGS_EN
        .out_zero(out_zero), .out_neg(out_neg),
`endif
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Behavioural logic_controller; invalid opcodes return junk the stage must suppress.
    function automatic logic [7:0] lu_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            8'h01:   return a & b;
            8'h02:   return a | b;
            8'h03:   return a ^ b;
            8'h04:   return ~(a & b);
            8'h05:   return ~(a | b);
            8'h06:   return ~(a ^ b);
            8'h07:   return ~a;
            default: return 8'hA5;
        endcase
    endfunction

    assign lu_y = lu_fn(lu_opcode, lu_a, lu_b);

    typedef struct {
        logic [7:0]    data;
        logic [AW-1:0] rd;
        logic          err;
        logic          zero;
        logic          neg;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [8];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_empty_on_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_rd", 32'(out_rd), 32'(e.rd));
                chk("out_err", 32'(out_err), 32'(e.err));
`ifdef LOGIC_FLAGS_EN
                chk("out_zero", 32'(out_zero), 32'(e.zero));
                chk("out_neg", 32'(out_neg), 32'(e.neg));
`endif
            end
        end
    end

    task automatic load(input logic [AW-1:0] addr, input logic [7:0] data);
        @(negedge clk);
        ext_wr_en = 1'b1; ext_wr_addr = addr; ext_wr_data = data;
        @(posedge clk); #1;
        ext_wr_en = 1'b0;
        model[addr] = data;
    endtask

    // poke: attempt an ext write of 8'h77 to R1 during EXEC (must be ignored).
    // abort: assert rst during EXEC; nothing is expected on the result stream.
    task automatic issue(input logic [7:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb, input logic xen, input logic [AW-1:0] xaddr,
                         input logic [7:0] xdata, input int hold, input logic poke, input logic abort);
        logic [7:0] a, b, res;
        logic       ok;
        exp_t       e;
        logic [7:0] snap_d;
        logic [AW-1:0] snap_rd;
        logic       snap_err;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_opcode = op; in_rd = rd; in_ra = ra; in_rb = rb;
        ext_wr_en = xen; ext_wr_addr = xaddr; ext_wr_data = xdata;
        a   = (xen && xaddr == ra) ? xdata : model[ra];
        b   = (op == 8'h07) ? 8'h00 : ((xen && xaddr == rb) ? xdata : model[rb]);
        ok  = (op >= 8'h01) && (op <= 8'h07);
        res = ok ? lu_fn(op, a, b) : 8'h00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ext_wr_en = poke; ext_wr_addr = 3'd1; ext_wr_data = 8'h77;
        if (xen) model[xaddr] = xdata;
        chk("exec_out_valid", 32'(out_valid), 32'd0);
        chk("exec_in_ready", 32'(in_ready), 32'd0);
        chk("lu_opcode", 32'(lu_opcode), 32'(op));
        chk("lu_a", 32'(lu_a), 32'(a));
        chk("lu_b", 32'(lu_b), 32'(b));
        if (abort) begin
            rst = 1'b1; #1;
            chk("abort_out_valid", 32'(out_valid), 32'd0);
            for (int i = 0; i < 8; i++) model[i] = 8'h00;
            @(posedge clk); #1;
            ext_wr_en = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        e.data = res; e.rd = rd; e.err = !ok; e.zero = (res == 8'h00); e.neg = res[7];
        sb.push_back(e);
        if (ok) model[rd] = res;
        @(posedge clk); #1;
        ext_wr_en = 1'b0;
        chk("resp_out_valid", 32'(out_valid), 32'd1);
        snap_d = out_data; snap_rd = out_rd; snap_err = out_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_data", 32'(out_data), 32'(snap_d));
            chk("hold_out_rd", 32'(out_rd), 32'(snap_rd));
            chk("hold_out_err", 32'(out_err), 32'(snap_err));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_lu_a", 32'(lu_a), 32'd0);
        chk("rst_lu_b", 32'(lu_b), 32'd0);
        chk("rst_lu_opcode", 32'(lu_opcode), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        load(3'd1, 8'hF0);
        load(3'd2, 8'h3C);
        issue(8'h01, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00, 0, 1'b1, 1'b0); // AND -> 30, ignored poke
        issue(8'h07, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00, 0, 1'b0, 1'b0); // NOT -> 0F
        issue(8'h02, 3'd5, 3'd3, 3'd3, 1'b0, 3'd0, 8'h00, 0, 1'b0, 1'b0); // R3 readback
        issue(8'h09, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00, 0, 1'b0, 1'b0); // invalid
        issue(8'h02, 3'd6, 3'd3, 3'd3, 1'b0, 3'd0, 8'h00, 5, 1'b0, 1'b0); // R3 unchanged, backpressure
        load(3'd1, 8'h55);
        issue(8'h03, 3'd0, 3'd1, 3'd2, 1'b1, 3'd2, 8'hAA, 0, 1'b0, 1'b0); // XOR with bypass -> FF
        issue(8'h00, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1, 1'b0, 1'b0); // opcode 0 invalid
        issue(8'h05, 3'd2, 3'd2, 3'd1, 1'b0, 3'd0, 8'h00, 0, 1'b0, 1'b0); // rd == ra
        for (int n = 0; n < 20; n++) begin
            issue(8'($urandom_range(0, 9)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom), $urandom_range(0, 2), 1'b0, 1'b0);
        end
        load(3'd6, 8'h81);
        issue(8'h01, 3'd6, 3'd6, 3'd6, 1'b0, 3'd0, 8'h00, 0, 1'b0, 1'b1); // reset during EXEC
        issue(8'h02, 3'd7, 3'd6, 3'd6, 1'b0, 3'd0, 8'h00, 0, 1'b0, 1'b0); // R6 back to 0
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
